// File: rtl/aco_pheromone_table_pkg.sv
// Shared constants, state encoding and deposit-level rule for the ACO pheromone table.
package aco_pheromone_table_pkg;

    localparam int DEF_X_NODES     = 4;
    localparam int DEF_Y_NODES     = 4;
    localparam int DEF_NODES       = DEF_X_NODES * DEF_Y_NODES;
    localparam int DEF_ROW_W       = $clog2(DEF_NODES);
    localparam int DEF_N           = 5;
    localparam int DEF_EVAP_PERIOD = 64;
    localparam int DEF_EVAP_STEP   = 1;

    localparam int PH_W    = 8;
    localparam int PH_MIN  = 0;
    localparam int PH_MAX  = 255;
    localparam int PH_INIT = 128;

    typedef enum logic [1:0] {
        ST_INIT = 2'd0,
        ST_RUN  = 2'd1,
        ST_EVAP = 2'd2
    } state_t;

    // Reinforcement strength from the ant's residual pheromone p and hop count m.
    // A zero hop count with any residual is treated as the strongest deposit.
    function automatic logic [2:0] deposit_level(input logic [6:0] p, input logic [6:0] m);
        logic [6:0] m2;
        logic [6:0] m3;
        m2 = m << 1;
        m3 = m2 + m;
        if (p > m3)
            return 3'd4;
        else if (p > m2)
            return 3'd3;
        else if (p > m)
            return 3'd2;
        else if (p != 7'd0)
            return 3'd1;
        else
            return 3'd0;
    endfunction

endpackage

// File: rtl/aco_pheromone_table_arbiter.sv
// N-way round-robin arbiter: one-hot combinational grant, pointer advances past the winner.
module aco_rr_arbiter #(
    parameter int  N  = 5,
    localparam int PW = (N > 1) ? $clog2(N) : 1
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         en,
    input  logic [0:N-1] req,
    output logic [0:N-1] grant
);

    logic [PW-1:0] ptr;
    logic [PW-1:0] win;
    logic          found;

    always_comb begin
        logic [PW-1:0] idx;
        grant = '0;
        win   = '0;
        found = 1'b0;
        for (int off = 0; off < N; off++) begin
            idx = PW'((int'(ptr) + off) % N);
            if (en && !found && req[idx]) begin
                grant[idx] = 1'b1;
                win        = idx;
                found      = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            ptr <= '0;
        else if (found)
            ptr <= (win == PW'(N - 1)) ? '0 : win + 1'b1;
    end

endmodule

// File: rtl/aco_pheromone_table.sv
// Per-router pheromone table: N lookup ports, arbitrated saturating deposits,
// an init sweep after reset and a periodic evaporation sweep.
module aco_pheromone_table
    import aco_pheromone_table_pkg::*;
#(
    parameter int  X_NODES     = DEF_X_NODES,
    parameter int  Y_NODES     = DEF_Y_NODES,
    parameter int  N           = DEF_N,
    parameter int  EVAP_PERIOD = DEF_EVAP_PERIOD,
    parameter int  EVAP_STEP   = DEF_EVAP_STEP,
    localparam int NODES       = X_NODES * Y_NODES,
    localparam int XW          = $clog2(X_NODES),
    localparam int YW          = $clog2(Y_NODES),
    localparam int RW          = $clog2(NODES)
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [0:N-1]                  i_rd_valid,
    input  logic [0:N-1][XW-1:0]          i_rd_x_dest,
    input  logic [0:N-1][YW-1:0]          i_rd_y_dest,
    output logic [0:N-1]                  o_rd_valid,
    output logic [0:N-1][0:N-2][PH_W-1:0] o_rd_ph,
    input  logic [0:N-1]                  i_upd_valid,
    output logic [0:N-1]                  o_upd_ready,
    input  logic [0:N-1][XW-1:0]          i_upd_x_dest,
    input  logic [0:N-1][YW-1:0]          i_upd_y_dest,
    input  logic [0:N-1][2:0]             i_upd_col,
    input  logic [0:N-1][4:0]             i_upd_ph_value,
    input  logic [0:N-1][RW-1:0]          i_upd_num_mem,
    output logic                          o_upd_err,
    output logic [1:0]                    o_state
);

    localparam int C  = N - 1;
    localparam int TW = (EVAP_PERIOD > 1) ? $clog2(EVAP_PERIOD) : 1;

    typedef logic [PH_W-1:0] ph_t;
    typedef logic [PH_W:0]   ext_t;
    typedef ph_t [0:C-1]     row_t;

    row_t                 tbl [NODES];
    state_t               state;
    logic [RW-1:0]        cnt;
    logic [TW-1:0]        timer;
    logic [0:N-1]         grant;
    logic                 gnt_any;
    logic                 col_ok;
    logic                 rd_en;
    logic [0:N-1][RW-1:0] rd_row;
    logic [RW-1:0]        upd_row;
    logic [2:0]           upd_col;
    logic [4:0]           upd_p;
    logic [RW-1:0]        upd_m;
    logic [2:0]           dep;
    logic                 wr_en;
    logic [RW-1:0]        wr_idx;
    row_t                 wr_row;

    function automatic logic [RW-1:0] row_idx(input logic [XW-1:0] x, input logic [YW-1:0] y);
        return RW'(y) * RW'(X_NODES) + RW'(x);
    endfunction

    function automatic ph_t sat_add(input ph_t e, input ext_t d);
        ext_t s;
        s = {1'b0, e} + d;
        return (s >= ext_t'(PH_MAX)) ? ph_t'(PH_MAX) : s[PH_W-1:0];
    endfunction

    // A borrow out of the extra top bit means the entry went below zero.
    function automatic ph_t sat_sub(input ph_t e, input ext_t d);
        ext_t s;
        s = {1'b0, e} - d;
        return (s[PH_W] || s[PH_W-1:0] <= ph_t'(PH_MIN)) ? ph_t'(PH_MIN) : s[PH_W-1:0];
    endfunction

    aco_rr_arbiter #(.N(N)) u_arb (
        .clk   (clk),
        .reset (reset),
        .en    (state == ST_RUN),
        .req   (i_upd_valid),
        .grant (grant)
    );

    assign o_upd_ready = grant;
    assign gnt_any     = |grant;
    assign rd_en       = (state != ST_INIT);
    assign o_state     = state;

    always_comb begin
        rd_row = '0;
        for (int i = 0; i < N; i++)
            rd_row[i] = row_idx(i_rd_x_dest[i], i_rd_y_dest[i]);
    end

    always_comb begin
        upd_row = '0;
        upd_col = '0;
        upd_p   = '0;
        upd_m   = '0;
        for (int k = 0; k < N; k++) begin
            if (grant[k]) begin
                upd_row = row_idx(i_upd_x_dest[k], i_upd_y_dest[k]);
                upd_col = i_upd_col[k];
                upd_p   = i_upd_ph_value[k];
                upd_m   = i_upd_num_mem[k];
            end
        end
    end

    assign dep    = deposit_level(7'(upd_p), 7'(upd_m));
    assign col_ok = (upd_col < 3'(C));

    // Only one row is written per cycle: the sweep row, or the granted update row in RUN.
    always_comb begin
        wr_en  = 1'b0;
        wr_idx = cnt;
        wr_row = tbl[cnt];
        case (state)
            ST_INIT: begin
                wr_en  = 1'b1;
                wr_row = {C{ph_t'(PH_INIT)}};
            end
            ST_EVAP: begin
                wr_en = 1'b1;
                for (int c = 0; c < C; c++)
                    wr_row[c] = sat_sub(tbl[cnt][c], ext_t'(EVAP_STEP));
            end
            ST_RUN: begin
                if (gnt_any && col_ok) begin
                    wr_en  = 1'b1;
                    wr_idx = upd_row;
                    for (int c = 0; c < C; c++)
                        wr_row[c] = (upd_col == 3'(c)) ? sat_add(tbl[upd_row][c], ext_t'(dep))
                                                        : sat_sub(tbl[upd_row][c], ext_t'(dep));
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (wr_en)
            tbl[wr_idx] <= wr_row;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= ST_INIT;
            cnt        <= '0;
            timer      <= '0;
            o_rd_valid <= '0;
            o_rd_ph    <= '0;
            o_upd_err  <= 1'b0;
        end else begin
            o_upd_err <= gnt_any && !col_ok;
            // Reads see the table as it was before this edge's write.
            for (int i = 0; i < N; i++) begin
                o_rd_valid[i] <= i_rd_valid[i] && rd_en;
                if (i_rd_valid[i] && rd_en)
                    o_rd_ph[i] <= tbl[rd_row[i]];
            end
            case (state)
                ST_INIT: begin
                    if (cnt == RW'(NODES - 1)) begin
                        state <= ST_RUN;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                ST_RUN: begin
                    if (EVAP_PERIOD != 0 && timer == TW'(EVAP_PERIOD - 1)) begin
                        state <= ST_EVAP;
                        timer <= '0;
                        cnt   <= '0;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                ST_EVAP: begin
                    if (cnt == RW'(NODES - 1)) begin
                        state <= ST_RUN;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: begin
                    state <= ST_INIT;
                    cnt   <= '0;
                end
            endcase
        end
    end

endmodule
